// File: rtl/id_retire_tracker_pkg.sv
// Shared configuration and types for the ID retire tracker.
// Purpose : default queue depth, data/register widths, and the
//           entry/packet types used by the tracker and its order FIFO.
// Ports   : none (package).
package id_retire_tracker_pkg;

  localparam int INSTRUCTION_QUEUE_DEPTH = 4;
  localparam int CFG_ID_W                = $clog2(INSTRUCTION_QUEUE_DEPTH);
  localparam int CFG_DATA_W              = 32;
  localparam int CFG_RD_W                = 5;

  typedef logic [CFG_ID_W-1:0] id_t;

  // One program-order slot: which ID, where it writes, whether it writes.
  typedef struct packed {
    id_t                 id;
    logic [CFG_RD_W-1:0] rd;
    logic                wb;
  } inflight_entry_t;

  // Everything the register file sees for one retirement.
  typedef struct packed {
    id_t                   id;
    logic [CFG_RD_W-1:0]   rd;
    logic                  wb;
    logic [CFG_DATA_W-1:0] data;
  } retire_packet_t;

endpackage

// File: rtl/id_order_fifo.sv
// Circular FIFO holding issued entries in program order.
// Purpose : pointer-based queue with one extra pointer bit so full and
//           empty are distinguishable without a separate counter.
// Ports   : clk, rst (async, active-low)
//           push/push_entry   write at tail (caller guarantees !full)
//           pop               advance head  (caller guarantees !empty)
//           head              oldest entry (combinational)
//           full, empty, count
module id_order_fifo
  import id_retire_tracker_pkg::*;
#(
  parameter int  DEPTH   = INSTRUCTION_QUEUE_DEPTH,
  parameter type entry_t = inflight_entry_t,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  entry_t        push_entry,
  input  logic          pop,
  output entry_t        head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wptr_reg;
  logic [AW:0] rptr_reg;
  entry_t      mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else begin
      if (push) wptr_reg <= wptr_reg + PTR_ONE;
      if (pop)  rptr_reg <= rptr_reg + PTR_ONE;
    end
  end

  // Entry storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_reg[AW-1:0]] <= push_entry;
  end

  assign empty = (wptr_reg == rptr_reg);
  assign full  = (wptr_reg[AW] != rptr_reg[AW]) &&
                 (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
  assign count = wptr_reg - rptr_reg;
  assign head  = mem[rptr_reg[AW-1:0]];

endmodule

// File: rtl/id_retire_tracker.sv
// In-order completion tracker downstream of the instruction ID generator.
// Purpose : records issued IDs in program order, captures out-of-order
//           writeback results, retires the oldest ID once its result is
//           present and frees it back to the generator via complete.
// Ports   : clk, rst (async, active-low)
//           issue_valid/issue_id/issue_rd/issue_wb, issue_ready
//           wb_valid/wb_id/wb_data
//           retire_valid/retire_ready, retire_id/rd/wb/data
//           complete/complete_id, inflight_count, protocol_error (sticky)
module id_retire_tracker
  import id_retire_tracker_pkg::*;
#(
  parameter int DEPTH  = INSTRUCTION_QUEUE_DEPTH,
  parameter int ID_W   = $clog2(DEPTH),
  parameter int DATA_W = CFG_DATA_W,
  parameter int RD_W   = CFG_RD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ID_W-1:0]   issue_id,
  input  logic [RD_W-1:0]   issue_rd,
  input  logic              issue_wb,
  output logic              issue_ready,
  input  logic              wb_valid,
  input  logic [ID_W-1:0]   wb_id,
  input  logic [DATA_W-1:0] wb_data,
  output logic              retire_valid,
  input  logic              retire_ready,
  output logic [ID_W-1:0]   retire_id,
  output logic [RD_W-1:0]   retire_rd,
  output logic              retire_wb,
  output logic [DATA_W-1:0] retire_data,
  output logic              complete,
  output logic [ID_W-1:0]   complete_id,
  output logic [ID_W:0]     inflight_count,
  output logic              protocol_error
);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [RD_W-1:0] rd;
    logic            wb;
  } entry_t;

  entry_t            push_entry;
  entry_t            head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              wb_err;
  logic              wb_accept;
  logic              issue_err;

  logic [DEPTH-1:0]  done_reg;
  logic [DEPTH-1:0]  done_next;
  logic [DEPTH-1:0]  inflight_reg;
  logic [DEPTH-1:0]  inflight_next;
  logic              protocol_error_reg;
  logic [DATA_W-1:0] data_mem [DEPTH];

  assign push_entry = '{id: issue_id, rd: issue_rd, wb: issue_wb};

  id_order_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_order_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (inflight_count)
  );

  // A pop in the same cycle does not make room: readiness is from state only.
  assign issue_ready  = !full;
  assign push         = issue_valid && !full;
  assign issue_err    = issue_valid && full;

  assign retire_valid = !empty && done_reg[head.id];
  assign pop          = retire_valid && retire_ready;
  assign retire_id    = head.id;
  assign retire_rd    = head.rd;
  assign retire_wb    = head.wb;
  assign retire_data  = data_mem[head.id];
  assign complete     = pop;
  assign complete_id  = head.id;

  // A result is only taken for an ID that is waiting for one and is not
  // simultaneously being (re)issued; anything else is flagged and dropped.
  assign wb_err    = wb_valid && (!inflight_reg[wb_id] || done_reg[wb_id] ||
                                  (issue_valid && issue_id == wb_id));
  assign wb_accept = wb_valid && !wb_err;

  // Per-ID next state. A push of an ID takes priority over its retirement,
  // so a freed ID reissued in the same cycle starts out not-done.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_id_state
      assign done_next[gi] =
        (push && issue_id == ID_W'(gi))      ? 1'b0 :
        (pop  && head.id  == ID_W'(gi))      ? 1'b0 :
        (wb_accept && wb_id == ID_W'(gi))    ? 1'b1 : done_reg[gi];
      assign inflight_next[gi] =
        (push && issue_id == ID_W'(gi))      ? 1'b1 :
        (pop  && head.id  == ID_W'(gi))      ? 1'b0 : inflight_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_reg           <= '0;
      inflight_reg       <= '0;
      protocol_error_reg <= 1'b0;
    end else begin
      done_reg     <= done_next;
      inflight_reg <= inflight_next;
      if (wb_err || issue_err) protocol_error_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wb_accept) data_mem[wb_id] <= wb_data;
  end

  assign protocol_error = protocol_error_reg;

endmodule

// File: tb/tb_id_retire_tracker.sv
module tb_id_retire_tracker;

  localparam int DEPTH  = 4;
  localparam int ID_W   = 2;
  localparam int DATA_W = 32;
  localparam int RD_W   = 5;

  logic              clk;
  logic              rst;
  logic              issue_valid;
  logic [ID_W-1:0]   issue_id;
  logic [RD_W-1:0]   issue_rd;
  logic              issue_wb;
  logic              issue_ready;
  logic              wb_valid;
  logic [ID_W-1:0]   wb_id;
  logic [DATA_W-1:0] wb_data;
  logic              retire_valid;
  logic              retire_ready;
  logic [ID_W-1:0]   retire_id;
  logic [RD_W-1:0]   retire_rd;
  logic              retire_wb;
  logic [DATA_W-1:0] retire_data;
  logic              complete;
  logic [ID_W-1:0]   complete_id;
  logic [ID_W:0]     inflight_count;
  logic              protocol_error;

  int n_checks = 0;
  int n_fail   = 0;

  id_retire_tracker #(
    .DEPTH(DEPTH), .ID_W(ID_W), .DATA_W(DATA_W), .RD_W(RD_W)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_id(issue_id), .issue_rd(issue_rd),
    .issue_wb(issue_wb), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data),
    .retire_valid(retire_valid), .retire_ready(retire_ready),
    .retire_id(retire_id), .retire_rd(retire_rd), .retire_wb(retire_wb),
    .retire_data(retire_data), .complete(complete), .complete_id(complete_id),
    .inflight_count(inflight_count), .protocol_error(protocol_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int id;
    int rd;
    int wb;
  } mentry_t;

  mentry_t     q[$];
  bit          m_done [DEPTH];
  logic [31:0] m_data [DEPTH];
  bit          m_err;

  function automatic bit m_inflight(input int id);
    foreach (q[i]) if (q[i].id == id) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      foreach (m_done[i]) m_done[i] = 1'b0;
      m_err = 1'b0;
    end else begin
      bit      do_push;
      bit      do_pop;
      bit      do_acc;
      int      hid;
      mentry_t e;
      do_push = issue_valid && (q.size() < DEPTH);
      do_pop  = (q.size() > 0) && m_done[q[0].id] && retire_ready;
      hid     = (q.size() > 0) ? q[0].id : -1;
      do_acc  = 1'b0;
      if (issue_valid && q.size() == DEPTH) m_err = 1'b1;
      if (wb_valid) begin
        if (!m_inflight(int'(wb_id)) || m_done[wb_id] ||
            (issue_valid && issue_id == wb_id)) m_err = 1'b1;
        else do_acc = 1'b1;
      end
      if (do_pop) begin
        $display("retire id=%0d rd=%0d wb=%0d data=%08h", hid, q[0].rd, q[0].wb, m_data[hid]);
        void'(q.pop_front());
        m_done[hid] = 1'b0;
      end
      if (do_acc) begin
        m_done[wb_id] = 1'b1;
        m_data[wb_id] = wb_data;
      end
      if (do_push) begin
        e.id = int'(issue_id); e.rd = int'(issue_rd); e.wb = int'(issue_wb);
        q.push_back(e);
        m_done[issue_id] = 1'b0;
      end
    end
  end

  // One compare process on every falling edge.
  always @(negedge clk) begin
    bit exp_rv;
    exp_rv = (q.size() > 0) && m_done[q[0].id];
    check("issue_ready", 64'(issue_ready), 64'(q.size() < DEPTH));
    check("retire_valid", 64'(retire_valid), 64'(exp_rv));
    check("inflight_count", 64'(inflight_count), 64'(q.size()));
    check("protocol_error", 64'(protocol_error), 64'(m_err));
    check("complete", 64'(complete), 64'(exp_rv && retire_ready));
    if (exp_rv) begin
      check("retire_id", 64'(retire_id), 64'(q[0].id));
      check("retire_rd", 64'(retire_rd), 64'(q[0].rd));
      check("retire_wb", 64'(retire_wb), 64'(q[0].wb));
      check("retire_data", 64'(retire_data), 64'(m_data[q[0].id]));
      if (retire_ready) check("complete_id", 64'(complete_id), 64'(q[0].id));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit iv, input int iid, input int ird, input bit iwb,
                       input bit wv, input int wid, input logic [31:0] wd, input bit rr);
    issue_valid  = iv;
    issue_id     = ID_W'(iid);
    issue_rd     = RD_W'(ird);
    issue_wb     = iwb;
    wb_valid     = wv;
    wb_id        = ID_W'(wid);
    wb_data      = wd;
    retire_ready = rr;
    #1;
  endtask

  task automatic idle(input bit rr);
    drive(0, 0, 0, 0, 0, 0, 32'h0, rr);
  endtask

  initial begin
    rst = 1'b0;
    idle(0);
    tick(); tick();
    rst = 1'b1;
    idle(0);
    check("lit_reset_count", 64'(inflight_count), 64'd0);
    check("lit_reset_ready", 64'(issue_ready), 64'd1);

    // In-order: IDs 3,2,1,0
    drive(1, 3, 5, 1, 0, 0, 0, 0); tick();
    drive(1, 2, 6, 1, 0, 0, 0, 0); tick();
    drive(1, 1, 7, 1, 0, 0, 0, 0); tick();
    drive(1, 0, 8, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 3, 32'hA0, 1);
    check("lit_full_count", 64'(inflight_count), 64'd4);
    check("lit_full_ready", 64'(issue_ready), 64'd0);
    check("lit_no_bypass", 64'(retire_valid), 64'd0);
    tick();
    drive(0, 0, 0, 0, 1, 2, 32'hA1, 1);
    check("lit_io_id3", 64'(retire_id), 64'd3);
    check("lit_io_rd5", 64'(retire_rd), 64'd5);
    check("lit_io_dataA0", 64'(retire_data), 64'hA0);
    check("lit_io_complete", 64'(complete), 64'd1);
    tick();
    drive(0, 0, 0, 0, 1, 1, 32'hA2, 1);
    check("lit_io_id2", 64'(retire_id), 64'd2);
    check("lit_io_dataA1", 64'(retire_data), 64'hA1);
    tick();
    drive(0, 0, 0, 0, 1, 0, 32'hA3, 1);
    check("lit_io_id1", 64'(retire_id), 64'd1);
    tick();
    idle(1);
    check("lit_io_id0_rd", 64'(retire_rd), 64'd8);
    check("lit_io_id0_data", 64'(retire_data), 64'hA3);
    tick();
    idle(0);
    check("lit_io_empty", 64'(inflight_count), 64'd0);

    // Out-of-order: issue 0,1,2; writeback 2,1,0
    drive(1, 0, 1, 1, 0, 0, 0, 0); tick();
    drive(1, 1, 2, 0, 0, 0, 0, 0); tick();
    drive(1, 2, 3, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 2, 32'h22, 1); tick();
    drive(0, 0, 0, 0, 1, 1, 32'h11, 1);
    check("lit_ooo_wait1", 64'(retire_valid), 64'd0);
    tick();
    drive(0, 0, 0, 0, 1, 0, 32'h00, 1);
    check("lit_ooo_wait2", 64'(retire_valid), 64'd0);
    tick();
    idle(1);
    check("lit_ooo_id0", 64'(retire_id), 64'd0);
    tick();
    idle(1);
    check("lit_ooo_id1", 64'(retire_id), 64'd1);
    check("lit_ooo_wb0", 64'(retire_wb), 64'd0);
    tick();
    idle(1);
    check("lit_ooo_data22", 64'(retire_data), 64'h22);
    tick();
    idle(0);

    // Full / backpressure
    for (int i = 0; i < 4; i++) begin
      drive(1, i, 9 + i, 1, 0, 0, 0, 0); tick();
    end
    drive(0, 0, 0, 0, 1, 0, 32'h55, 0);
    check("lit_bp_ready", 64'(issue_ready), 64'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(0);
      check("lit_bp_hold_valid", 64'(retire_valid), 64'd1);
      check("lit_bp_hold_data", 64'(retire_data), 64'h55);
      check("lit_bp_hold_complete", 64'(complete), 64'd0);
      tick();
    end
    idle(1);
    check("lit_bp_complete", 64'(complete), 64'd1);
    check("lit_bp_ready_same", 64'(issue_ready), 64'd0);
    tick();
    idle(0);
    check("lit_bp_ready_after", 64'(issue_ready), 64'd1);
    check("lit_bp_count", 64'(inflight_count), 64'd3);

    // Reuse: retire ID1 while reissuing ID1
    drive(0, 0, 0, 0, 1, 1, 32'h77, 0); tick();
    drive(1, 1, 20, 1, 0, 0, 0, 1);
    check("lit_reuse_complete_id", 64'(complete_id), 64'd1);
    tick();
    drive(0, 0, 0, 0, 1, 2, 32'h88, 1);
    check("lit_reuse_count", 64'(inflight_count), 64'd3);
    tick();
    drive(0, 0, 0, 0, 1, 3, 32'h99, 1); tick();
    idle(1); tick();
    idle(1);
    check("lit_reuse_not_done", 64'(retire_valid), 64'd0);
    tick();
    drive(0, 0, 0, 0, 1, 1, 32'h78, 1); tick();
    idle(1);
    check("lit_reuse_rd20", 64'(retire_rd), 64'd20);
    check("lit_reuse_data78", 64'(retire_data), 64'h78);
    tick();
    idle(0);

    // Issue while full
    for (int i = 0; i < 4; i++) begin
      drive(1, i, 1 + i, 1, 0, 0, 0, 0); tick();
    end
    drive(1, 0, 9, 1, 0, 0, 0, 0); tick();
    idle(0);
    check("lit_err_full_flag", 64'(protocol_error), 64'd1);
    check("lit_err_full_count", 64'(inflight_count), 64'd4);
    tick();

    // Reset mid-traffic
    drive(0, 0, 0, 0, 1, 0, 32'h5A, 0); tick();
    idle(1);
    rst = 1'b0;
    #1;
    check("lit_rst_count", 64'(inflight_count), 64'd0);
    check("lit_rst_valid", 64'(retire_valid), 64'd0);
    check("lit_rst_complete", 64'(complete), 64'd0);
    check("lit_rst_perr", 64'(protocol_error), 64'd0);
    tick();
    check("lit_rst_ready", 64'(issue_ready), 64'd1);
    rst = 1'b1;
    idle(0); tick();

    // Writeback of an ID not in flight
    drive(0, 0, 0, 0, 1, 2, 32'hDEAD, 1); tick();
    idle(1);
    check("lit_wberr_flag", 64'(protocol_error), 64'd1);
    check("lit_wberr_count", 64'(inflight_count), 64'd0);
    tick();
    drive(1, 2, 4, 1, 0, 0, 0, 1); tick();
    idle(1);
    check("lit_wberr_no_done", 64'(retire_valid), 64'd0);
    check("lit_wberr_sticky", 64'(protocol_error), 64'd1);
    tick();
    drive(0, 0, 0, 0, 1, 2, 32'h42, 1); tick();
    idle(1);
    check("lit_wberr_data42", 64'(retire_data), 64'h42);
    tick();
    idle(0); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
